// File: rtl/mapping_ptr_dispatcher.sv
// mapping_ptr_dispatcher: walks a BRAM mapping table and dispatches decoded pointers to per-channel request ports.
module mapping_ptr_dispatcher #(
  parameter int          NUM_CH      = 4,
  parameter logic [31:0] START_ADDR  = 32'h4580_0000,
  parameter int          TABLE_DEPTH = 256,
  parameter int          PATCH_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            table_len,
  input  logic [PATCH_W-1:0]    patch_total,
  output logic [31:0]           ram_addr,
  output logic                  ram_en,
  input  logic [31:0]           ram_rd_data,
  output logic [NUM_CH-1:0]     req_valid,
  input  logic [NUM_CH-1:0]     req_ready,
  output logic [NUM_CH*4-1:0]   req_way,
  output logic [NUM_CH*24-1:0]  req_row,
  input  logic                  UW_busy,
  output logic                  UW_ready,
  output logic [PATCH_W-1:0]    patch_num,
  output logic                  busy,
  output logic                  done,
  output logic                  ch_err
);
  localparam int WW = TABLE_DEPTH > 1 ? $clog2(TABLE_DEPTH) : 1;
  typedef enum logic [2:0] {IDLE, RD, CAP, ISSUE, NEXT, HANDOFF, FIN} state_t;
  state_t             state;
  logic [WW-1:0]      widx;
  logic [7:0]         ent_cnt;
  logic [7:0]         len;
  logic [PATCH_W-1:0] total;
  logic               bad;
  logic [3:0]         rd_ch;
  logic               rd_ok;
  logic               handoff_go;
  assign rd_ch      = ram_rd_data[27:24];
  assign rd_ok      = rd_ch < 4'(NUM_CH);
  // The first patch hands off unconditionally; later ones wait for the U-Net to go idle.
  assign handoff_go = state == HANDOFF && (patch_num == '0 || !UW_busy);
  assign UW_ready   = handoff_go;
  assign busy       = state != IDLE;
  assign done       = state == FIN;
  assign ram_addr   = START_ADDR + (32'(widx) << 2);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      widx      <= '0;
      ent_cnt   <= '0;
      len       <= '0;
      total     <= '0;
      patch_num <= '0;
      bad       <= 1'b0;
      ch_err    <= 1'b0;
      ram_en    <= 1'b0;
      req_valid <= '0;
      req_way   <= '0;
      req_row   <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          len       <= table_len;
          total     <= patch_total;
          widx      <= '0;
          ent_cnt   <= '0;
          patch_num <= '0;
          ch_err    <= 1'b0;
          if (table_len != 8'd0 && patch_total != '0) begin
            state  <= RD;
            ram_en <= 1'b1;
          end else state <= FIN;
        end
        RD: begin
          ram_en <= 1'b0;
          state  <= CAP;
        end
        CAP: begin
          bad   <= !rd_ok;
          state <= ISSUE;
          for (int c = 0; c < NUM_CH; c++) begin
            req_valid[c] <= rd_ok && rd_ch == 4'(c);
            if (rd_ch == 4'(c)) begin
              req_way[c*4 +: 4]   <= ram_rd_data[31:28];
              req_row[c*24 +: 24] <= ram_rd_data[23:0];
            end
          end
        end
        ISSUE: if (bad) begin
          ch_err <= 1'b1;
          state  <= NEXT;
        end else if (|(req_valid & req_ready)) begin
          req_valid <= '0;
          state     <= NEXT;
        end
        NEXT: begin
          widx    <= widx == WW'(TABLE_DEPTH - 1) ? '0 : widx + WW'(1);
          ent_cnt <= ent_cnt + 8'd1;
          if (ent_cnt + 8'd1 == len) state <= HANDOFF;
          else begin
            state  <= RD;
            ram_en <= 1'b1;
          end
        end
        HANDOFF: if (handoff_go) begin
          ent_cnt <= '0;
          if (patch_num == total - PATCH_W'(1)) state <= FIN;
          else begin
            patch_num <= patch_num + PATCH_W'(1);
            state     <= RD;
            ram_en    <= 1'b1;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mapping_ptr_dispatcher.sv
// tb_mapping_ptr_dispatcher: directed checks of table walk, handshakes, handoff, errors and reset.
module tb_mapping_ptr_dispatcher;
  localparam logic [31:0] SA = 32'h4580_0000;
  logic        clk = 1'b0;
  logic        rst, start, UW_busy, UW_ready, ram_en, busy, done, ch_err;
  logic [7:0]  table_len, patch_total, patch_num;
  logic [31:0] ram_addr, ram_rd_data, off;
  logic [3:0]  req_valid, req_ready;
  logic [15:0] req_way;
  logic [95:0] req_row;
  logic [31:0] mem [0:3];
  int vectors = 0;
  int miscompares = 0;

  mapping_ptr_dispatcher #(.NUM_CH(4), .START_ADDR(SA), .TABLE_DEPTH(4), .PATCH_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .table_len(table_len), .patch_total(patch_total),
    .ram_addr(ram_addr), .ram_en(ram_en), .ram_rd_data(ram_rd_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_way(req_way), .req_row(req_row),
    .UW_busy(UW_busy), .UW_ready(UW_ready), .patch_num(patch_num),
    .busy(busy), .done(done), .ch_err(ch_err));

  always #5 clk = ~clk;
  assign off = ram_addr - SA;
  always @(posedge clk) if (ram_en) ram_rd_data <= mem[off[3:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " valid"}, 32'(req_valid), 32'h0);
    chk({tag, " way"}, 32'(req_way), 32'h0);
    chk({tag, " row"}, 32'(|req_row), 32'h0);
    chk({tag, " ram_en"}, 32'(ram_en), 32'h0);
    chk({tag, " ram_addr"}, ram_addr, SA);
    chk({tag, " uw_ready"}, 32'(UW_ready), 32'h0);
    chk({tag, " patch_num"}, 32'(patch_num), 32'h0);
    chk({tag, " busy"}, 32'(busy), 32'h0);
    chk({tag, " done"}, 32'(done), 32'h0);
    chk({tag, " ch_err"}, 32'(ch_err), 32'h0);
  endtask

  task automatic run_to_idle(input string tag, input int lim);
    for (int i = 0; i < lim && busy; i++) step(1);
    chk({tag, " idle"}, 32'(busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] q[$];
    logic [3:0]  vor;
    int rdy_cnt, dcnt, pn, ren, first_done;
    rst = 1'b1; start = 1'b0; UW_busy = 1'b0; table_len = '0; patch_total = '0; req_ready = '0;
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;
    step(2);
    chk_reset("reset");
    rst = 1'b0;
    step(1);
    // Two entries on channels 1 and 2, ready always high, busy U-Net ignored for patch 0
    mem[0] = 32'h3100_0010; mem[1] = 32'h5200_0020;
    req_ready = 4'hF; UW_busy = 1'b1; table_len = 8'd2; patch_total = 8'd1; start = 1'b1;
    step(1); start = 1'b0;
    chk("t1 rd en", 32'(ram_en), 32'h1);
    chk("t1 rd addr", ram_addr, SA);
    chk("t1 busy", 32'(busy), 32'h1);
    step(1);
    chk("t1 no early valid", 32'(req_valid), 32'h0);
    step(1);
    chk("t1 valid ch1", 32'(req_valid), 32'h2);
    chk("t1 way ch1", 32'(req_way[7:4]), 32'h3);
    chk("t1 row ch1", 32'(req_row[47:24]), 32'h10);
    step(1);
    chk("t1 valid drop", 32'(req_valid), 32'h0);
    step(1);
    chk("t1 rd2 en", 32'(ram_en), 32'h1);
    chk("t1 rd2 addr", ram_addr, SA + 32'd4);
    step(2);
    chk("t1 valid ch2", 32'(req_valid), 32'h4);
    chk("t1 way ch2", 32'(req_way[11:8]), 32'h5);
    chk("t1 row ch2", 32'(req_row[71:48]), 32'h20);
    step(2);
    chk("t1 uw_ready", 32'(UW_ready), 32'h1);
    step(1);
    chk("t1 done", 32'(done), 32'h1);
    chk("t1 uw_ready drop", 32'(UW_ready), 32'h0);
    step(1);
    chk("t1 done drop", 32'(done), 32'h0);
    chk("t1 idle", 32'(busy), 32'h0);
    chk("t1 patch_num", 32'(patch_num), 32'h0);
    // Back-pressure on channel 1 for five cycles
    req_ready = 4'b1101; UW_busy = 1'b0; start = 1'b1;
    step(1); start = 1'b0;
    step(2);
    for (int i = 0; i < 5; i++) begin
      chk("t2 hold valid", 32'(req_valid), 32'h2);
      chk("t2 hold way", 32'(req_way[7:4]), 32'h3);
      chk("t2 hold row", 32'(req_row[47:24]), 32'h10);
      if (i < 4) step(1);
    end
    req_ready = 4'hF;
    step(1);
    chk("t2 handshake", 32'(req_valid), 32'h0);
    chk("t2 no rd yet", 32'(ram_en), 32'h0);
    step(1);
    chk("t2 next rd en", 32'(ram_en), 32'h1);
    chk("t2 next rd addr", ram_addr, SA + 32'd4);
    run_to_idle("t2", 20);
    // Three patches, U-Net busy during the second handoff
    mem[2] = 32'h7000_0030; table_len = 8'd1; patch_total = 8'd3; start = 1'b1;
    step(1); start = 1'b0;
    step(4);
    chk("t3 uw_ready p0", 32'(UW_ready), 32'h1);
    chk("t3 patch_num p0", 32'(patch_num), 32'h0);
    step(1);
    chk("t3 patch_num p1", 32'(patch_num), 32'h1);
    UW_busy = 1'b1;
    rdy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      rdy_cnt += int'(UW_ready);
    end
    chk("t3 uw_ready held off", 32'(rdy_cnt), 32'h0);
    UW_busy = 1'b0;
    #1;
    chk("t3 uw_ready p1", 32'(UW_ready), 32'h1);
    chk("t3 patch_num at p1 handoff", 32'(patch_num), 32'h1);
    rdy_cnt = 0; dcnt = 0; pn = -1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (UW_ready) begin rdy_cnt++; pn = int'(patch_num); end
      dcnt += int'(done);
    end
    chk("t3 uw_ready count p2", 32'(rdy_cnt), 32'h1);
    chk("t3 patch_num p2", 32'(pn), 32'h2);
    chk("t3 done pulses", 32'(dcnt), 32'h1);
    chk("t3 idle", 32'(busy), 32'h0);
    // Entry addressed to channel 9
    mem[0] = 32'h1900_0001; patch_total = 8'd1; start = 1'b1;
    step(1); start = 1'b0;
    vor = '0; dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      vor |= req_valid;
      dcnt += int'(done);
    end
    chk("t4 no valid", 32'(vor), 32'h0);
    chk("t4 ch_err", 32'(ch_err), 32'h1);
    chk("t4 done", 32'(dcnt), 32'h1);
    chk("t4 idle", 32'(busy), 32'h0);
    // Word index wraps across patches with depth 4
    for (int i = 0; i < 4; i++) mem[i] = 32'h1000_0000 + 32'(i);
    table_len = 8'd3; patch_total = 8'd2; start = 1'b1;
    step(1); start = 1'b0;
    chk("t5 ch_err cleared", 32'(ch_err), 32'h0);
    for (int i = 0; i < 60 && busy; i++) begin
      if (ram_en) q.push_back(ram_addr);
      step(1);
    end
    chk("t5 idle", 32'(busy), 32'h0);
    chk("t5 rd count", 32'(q.size()), 32'd6);
    for (int j = 0; j < 6 && j < q.size(); j++)
      chk($sformatf("t5 addr%0d", j), q[j], SA + 32'd4 * ((j < 4) ? 32'(j) : 32'(j - 4)));
    // Reset mid-issue, then a zero-length run
    mem[0] = 32'h2000_0005; req_ready = 4'h0; table_len = 8'd1; patch_total = 8'd1; start = 1'b1;
    step(1); start = 1'b0;
    step(2);
    chk("t6 valid ch0", 32'(req_valid), 32'h1);
    #2 rst = 1'b1;
    #1 chk_reset("t6 async reset");
    step(1); rst = 1'b0;
    step(1);
    table_len = 8'd0; start = 1'b1;
    ren = 0; dcnt = 0; first_done = 0;
    for (int i = 1; i <= 3; i++) begin
      step(1); start = 1'b0;
      ren |= int'(ram_en);
      dcnt += int'(done);
      if (done && first_done == 0) first_done = i;
    end
    chk("t6 zero len no ram_en", 32'(ren), 32'h0);
    chk("t6 zero len done count", 32'(dcnt), 32'h1);
    chk("t6 zero len done latency", 32'(first_done >= 1 && first_done <= 2), 32'h1);
    chk("t6 idle", 32'(busy), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
